// File: rtl/ez8_mem_pkg.sv
// Shared types and default widths for the memory arbiter slice.
package ez8_mem_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// mem_arb_tag_pipe: two-stage shift register that carries the owner of each
// granted read alongside the memory latency, and decodes the per-port
// read-return strobes at the second stage.
module mem_arb_tag_pipe
    import ez8_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push_valid_i,
    input  logic [1:0] push_owner_i,
    output logic       core_sel_o,
    output logic       dma_sel_o
);

    logic       s1_valid_q;
    logic [1:0] s1_owner_q;
    logic       s2_valid_q;
    logic [1:0] s2_owner_q;

    // Shift the read tag one stage per cycle; reset drops anything in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_owner_q <= OWN_NONE;
            s2_valid_q <= 1'b0;
            s2_owner_q <= OWN_NONE;
        end else begin
            s1_valid_q <= push_valid_i;
            s1_owner_q <= push_owner_i;
            s2_valid_q <= s1_valid_q;
            s2_owner_q <= s1_owner_q;
        end
    end

    assign core_sel_o = s2_valid_q && (s2_owner_q == OWN_CORE);
    assign dma_sel_o  = s2_valid_q && (s2_owner_q == OWN_DMA);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single mem_ctrl port between the core and a
// DMA/debug requester. Grants are combinational, the winning access is
// registered onto the mem_ctrl lines, and read data is steered back to its
// owner two cycles after the grant.
// Optional starvation counters are built when MEM_ARB_FAIRNESS_EN is defined.
module mem_arbiter
    import ez8_mem_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic              dma_lock,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_readaddr,
    output logic [ADDR_W-1:0] mem_writeaddr,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [1:0]        owner
);

    arb_state_t state_q, state_d;
    logic       core_gnt_c, dma_gnt_c;
    logic       dma_prio;    // DMA has waited long enough to win contention
    logic       force_core;  // core has waited long enough to break a lock

`ifdef MEM_ARB_FAIRNESS_EN
    logic [3:0] dma_wait_q, dma_wait_d;
    logic [3:0] core_wait_q, core_wait_d;

    assign dma_prio   = (dma_wait_q  >= 4'(STARVE_LIMIT));
    assign force_core = (core_wait_q >= 4'(STARVE_LIMIT));

    // Wait counters: DMA starvation in ARB, core starvation while locked.
    always_comb begin
        dma_wait_d  = dma_wait_q;
        core_wait_d = core_wait_q;
        if (dma_gnt_c) begin
            dma_wait_d = '0;
        end else if ((state_q == ARB) && dma_req && (dma_wait_q != 4'hF)) begin
            dma_wait_d = dma_wait_q + 4'd1;
        end
        if (state_d == ARB) begin
            core_wait_d = '0;
        end else if ((state_q == LOCKED) && core_req && (core_wait_q != 4'hF)) begin
            core_wait_d = core_wait_q + 4'd1;
        end
    end

    // Wait counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dma_wait_q  <= '0;
            core_wait_q <= '0;
        end else begin
            dma_wait_q  <= dma_wait_d;
            core_wait_q <= core_wait_d;
        end
    end
`else
    // Strict core priority; the limit only matters with the counters built.
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT != 0);
    assign dma_prio   = 1'b0;
    assign force_core = 1'b0;
`endif

    // Grant decision and lock tracking.
    always_comb begin
        state_d    = state_q;
        core_gnt_c = 1'b0;
        dma_gnt_c  = 1'b0;
        case (state_q)
            ARB: begin
                if (core_req && !(dma_req && dma_prio)) begin
                    core_gnt_c = 1'b1;
                end else if (dma_req) begin
                    dma_gnt_c = 1'b1;
                end
                if (dma_gnt_c && dma_lock) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (force_core) begin
                    // Break the lock for one core access, whatever dma_lock says.
                    core_gnt_c = core_req;
                    state_d    = ARB;
                end else begin
                    dma_gnt_c = dma_req;
                    if (!dma_lock) begin
                        state_d = ARB;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Arbiter state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // Grants are forced low while reset is held so every output reads 0.
    assign core_gnt = core_gnt_c & reset_n;
    assign dma_gnt  = dma_gnt_c & reset_n;

    logic              any_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign any_gnt   = core_gnt | dma_gnt;
    assign sel_we    = core_gnt ? core_we    : dma_we;
    assign sel_addr  = core_gnt ? core_addr  : dma_addr;
    assign sel_wdata = core_gnt ? core_wdata : dma_wdata;

    logic [ADDR_W-1:0] readaddr_q, writeaddr_q;
    logic [DATA_W-1:0] writedata_q;
    logic              write_q;
    logic [1:0]        owner_q;

    // Register the winning access onto the mem_ctrl lines; lines hold when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readaddr_q  <= '0;
            writeaddr_q <= '0;
            writedata_q <= '0;
            write_q     <= 1'b0;
            owner_q     <= OWN_NONE;
        end else begin
            write_q <= any_gnt && sel_we;
            if (any_gnt) begin
                owner_q <= core_gnt ? OWN_CORE : OWN_DMA;
                if (sel_we) begin
                    writeaddr_q <= sel_addr;
                    writedata_q <= sel_wdata;
                end else begin
                    readaddr_q <= sel_addr;
                end
            end
        end
    end

    assign mem_readaddr  = readaddr_q;
    assign mem_writeaddr = writeaddr_q;
    assign mem_writedata = writedata_q;
    assign mem_write     = write_q;
    assign owner         = owner_q;

    mem_arb_tag_pipe u_tag_pipe (
        .clk          (clk),
        .reset_n      (reset_n),
        .push_valid_i (any_gnt && !sel_we),
        .push_owner_i (core_gnt ? OWN_CORE : OWN_DMA),
        .core_sel_o   (core_rvalid),
        .dma_sel_o    (dma_rvalid)
    );

    logic [DATA_W-1:0] core_rdata_q, dma_rdata_q;

    // Remember the last returned word per port so a non-owner's rdata holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_rdata_q <= '0;
            dma_rdata_q  <= '0;
        end else begin
            if (core_rvalid) begin
                core_rdata_q <= mem_readdata;
            end
            if (dma_rvalid) begin
                dma_rdata_q <= mem_readdata;
            end
        end
    end

    assign core_rdata = core_rvalid ? mem_readdata : core_rdata_q;
    assign dma_rdata  = dma_rvalid  ? mem_readdata : dma_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: the driver computes expected grants,
// memory-line values and read returns from an abstract model and queues
// them; a negedge monitor pops and compares against the DUT.
module tb_mem_arbiter;

    localparam int LIMIT = 4;
`ifdef MEM_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       core_req = 1'b0, core_we = 1'b0;
    logic [7:0] core_addr = '0, core_wdata = '0;
    logic       dma_req = 1'b0, dma_we = 1'b0, dma_lock = 1'b0;
    logic [7:0] dma_addr = '0, dma_wdata = '0;
    logic       core_gnt, core_rvalid, dma_gnt, dma_rvalid, mem_write;
    logic [7:0] core_rdata, dma_rdata, mem_readaddr, mem_writeaddr, mem_writedata;
    logic [7:0] mem_readdata;
    logic [1:0] owner;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
        .core_rdata(core_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .dma_rdata(dma_rdata),
        .mem_readaddr(mem_readaddr), .mem_writeaddr(mem_writeaddr),
        .mem_writedata(mem_writedata), .mem_write(mem_write),
        .mem_readdata(mem_readdata), .owner(owner)
    );

    // Behavioural mem_ctrl: synchronous read, write-first on the same address.
    logic [7:0] mem_arr [256];
    always @(posedge clk) begin
        if (mem_write) mem_arr[mem_writeaddr] <= mem_writedata;
        mem_readdata <= (mem_write && mem_writeaddr == mem_readaddr) ? mem_writedata
                                                                     : mem_arr[mem_readaddr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int due; bit gc; bit gd; } gnt_exp_t;
    typedef struct { int due; bit we; logic [7:0] waddr; logic [7:0] wdata;
                     logic [7:0] raddr; logic [1:0] own; } mem_exp_t;
    typedef struct { int due; bit is_dma; logic [7:0] data; } rd_exp_t;

    gnt_exp_t gnt_q[$];
    mem_exp_t mem_q[$];
    rd_exp_t  rd_q[$];

    int n_pass = 0, n_total = 0;
    bit in_reset = 1'b1;

    // Abstract model: memory contents in program order, lock flag, wait counts.
    logic [7:0] ref_mem [256];
    bit         m_locked;
    int         m_dwait, m_cwait;
    logic [7:0] exp_waddr, exp_wdata, exp_raddr;
    logic [1:0] exp_own;
    logic [7:0] last_c, last_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        m_locked = 1'b0; m_dwait = 0; m_cwait = 0;
        exp_waddr = '0; exp_wdata = '0; exp_raddr = '0; exp_own = 2'd0;
        last_c = '0; last_d = '0;
    endtask

    // One clock of stimulus: drive inputs, predict the response, queue it.
    task automatic step(input bit creq, input bit cwe, input logic [7:0] caddr,
                        input logic [7:0] cwd, input bit dreq, input bit dwe,
                        input bit dlock, input logic [7:0] daddr, input logic [7:0] dwd);
        bit gc, gd, leave, we, ew;
        logic [7:0] a;
        @(posedge clk); #1;
        core_req = creq; core_we = cwe; core_addr = caddr; core_wdata = cwd;
        dma_req = dreq; dma_we = dwe; dma_lock = dlock; dma_addr = daddr; dma_wdata = dwd;
        gc = 1'b0; gd = 1'b0; leave = 1'b0; ew = 1'b0;
        if (!m_locked) begin
            if (creq && dreq) begin
                if (FAIR && m_dwait >= LIMIT) gd = 1'b1; else gc = 1'b1;
            end else begin
                gc = creq; gd = dreq;
            end
            if (gd) m_dwait = 0;
            else if (dreq && m_dwait < 15) m_dwait++;
            if (gd && dlock) m_locked = 1'b1;
        end else begin
            if (FAIR && m_cwait >= LIMIT) begin
                gc = creq; leave = 1'b1;
            end else begin
                gd = dreq; leave = !dlock;
            end
            if (gd) m_dwait = 0;
            if (leave) begin m_locked = 1'b0; m_cwait = 0; end
            else if (creq) m_cwait++;
        end
        gnt_q.push_back('{cyc, gc, gd});
        if (gc || gd) begin
            we = gc ? cwe : dwe;
            a  = gc ? caddr : daddr;
            exp_own = gc ? 2'd1 : 2'd2;
            if (we) begin
                ew = 1'b1; exp_waddr = a; exp_wdata = gc ? cwd : dwd;
                ref_mem[a] = exp_wdata;
            end else begin
                exp_raddr = a;
                rd_q.push_back('{cyc + 2, gd, ref_mem[a]});
            end
        end
        mem_q.push_back('{cyc + 1, ew, exp_waddr, exp_wdata, exp_raddr, exp_own});
    endtask

    // Monitor: compare whatever is due this cycle; rvalid must be 0 otherwise.
    always @(negedge clk) begin : monitor
        gnt_exp_t g;
        mem_exp_t m;
        rd_exp_t  r;
        logic     ecv, edv;
        if (in_reset) begin
            check("reset_outputs", {9'd0, core_gnt, dma_gnt, core_rvalid, dma_rvalid,
                                    mem_write, owner, core_rdata, dma_rdata}, 32'd0);
            check("reset_lines", {8'd0, mem_readaddr, mem_writeaddr, mem_writedata}, 32'd0);
        end else begin
            if (gnt_q.size() > 0 && gnt_q[0].due == cyc) begin
                g = gnt_q.pop_front();
                check("core_gnt", core_gnt, g.gc);
                check("dma_gnt", dma_gnt, g.gd);
            end
            if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
                m = mem_q.pop_front();
                check("mem_write", mem_write, m.we);
                check("mem_writeaddr", mem_writeaddr, m.waddr);
                check("mem_writedata", mem_writedata, m.wdata);
                check("mem_readaddr", mem_readaddr, m.raddr);
                check("owner", owner, m.own);
            end
            ecv = 1'b0; edv = 1'b0;
            if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                r = rd_q.pop_front();
                if (r.is_dma) begin edv = 1'b1; last_d = r.data; end
                else begin ecv = 1'b1; last_c = r.data; end
            end
            check("core_rvalid", core_rvalid, ecv);
            check("dma_rvalid", dma_rvalid, edv);
            check("core_rdata", core_rdata, last_c);
            check("dma_rdata", dma_rdata, last_d);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit lk;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1; reset_n = 1'b1; in_reset = 1'b0;

        // Simultaneous reads: core wins, DMA goes next cycle.
        step(1, 0, 8'h10, 8'h00, 1, 0, 0, 8'h20, 8'h00);
        step(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h20, 8'h00);
        // Locked DMA write, core blocked until the lock drops, then reads it back.
        step(0, 0, 8'h00, 8'h00, 1, 1, 1, 8'h33, 8'h5A);
        for (int i = 0; i < 3; i++) step(1, 0, 8'h33, 8'h00, 0, 0, 1, 8'h00, 8'h00);
        step(1, 0, 8'h33, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        step(1, 0, 8'h33, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        // Back-to-back core reads.
        for (int i = 0; i < 4; i++) step(1, 0, 8'(i), 8'h00, 0, 0, 0, 8'h00, 8'h00);
        // Write then read of the same address on the next cycle.
        step(1, 1, 8'h07, 8'hC3, 0, 0, 0, 8'h00, 8'h00);
        step(1, 0, 8'h07, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        step(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);

        // Reset one cycle after a read grant: the read must never return.
        step(1, 0, 8'h44, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        @(posedge clk); #1;
        core_req = 1'b1; dma_req = 1'b1; reset_n = 1'b0; in_reset = 1'b1;
        gnt_q.delete(); mem_q.delete(); rd_q.delete();
        model_reset();
        repeat (3) @(posedge clk);
        #1; core_req = 1'b0; dma_req = 1'b0; reset_n = 1'b1; in_reset = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);

        // Both requesting continuously, no lock.
        for (int i = 0; i < 12; i++)
            step(1, 0, 8'(i), 8'h00, 1, 0, 0, 8'(8'h80 + i), 8'h00);
        // DMA holds the lock while the core keeps asking.
        step(0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h90, 8'h00);
        for (int i = 0; i < 10; i++)
            step(1, 0, 8'(i), 8'h00, 1, 0, 1, 8'(8'hA0 + i), 8'h00);
        step(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);

        // Randomized traffic on a small address window with a sticky lock.
        lk = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) lk = !lk;
            step($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 15)), 8'($urandom),
                 $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), lk,
                 8'($urandom_range(0, 15)), 8'($urandom));
        end
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);

        repeat (3) @(negedge clk);
        #1;
        check("pending_reads", rd_q.size(), 0);
        check("pending_lines", mem_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single memory port of `mem_ctrl` between the core pipeline and a DMA/debug requester. Decides one grant per cycle, registers the winning access onto the `mem_ctrl` read/write address and data lines, and routes the synchronous read data back to the owner two cycles later. Sits between the core's load/store stage and `mem_ctrl`, with the DMA port exposed at top level.

## Interface
- `ADDR_W`, 8, address width
- `DATA_W`, 8, data width
- `STARVE_LIMIT`, 4, wait-cycle threshold for the fairness logic (1..15)

- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous active-low reset
- `core_req`, `core_we`  in  1  core access request; 1 = write
- `core_addr`  in  ADDR_W;  `core_wdata`  in  DATA_W
- `core_gnt`  out  1  access accepted this cycle
- `core_rvalid`  out  1;  `core_rdata`  out  DATA_W  read return
- `dma_req`, `dma_we`, `dma_lock`  in  1  DMA request, write, bus-lock
- `dma_addr`  in  ADDR_W;  `dma_wdata`  in  DATA_W
- `dma_gnt`  out  1;  `dma_rvalid`  out  1;  `dma_rdata`  out  DATA_W
- `mem_readaddr`, `mem_writeaddr`  out  ADDR_W  to `mem_ctrl`
- `mem_writedata`  out  DATA_W;  `mem_write`  out  1  write strobe
- `mem_readdata`  in  DATA_W  from `mem_ctrl`, valid 1 cycle after `mem_readaddr`
- `owner`  out  2  debug: 0 none, 1 core, 2 DMA (last grant)

## Operation
- FSM states: ARB, LOCKED.
- ARB: `gnt` is combinational. Core wins if both request; DMA wins if it requests alone. Exception: see Configuration.
- A transfer occurs on the clock edge where `req && gnt`. At most one grant per cycle; `core_gnt && dma_gnt` is never 1.
- ARB → LOCKED when DMA is granted with `dma_lock=1`.
- LOCKED: `core_gnt=0`. `dma_gnt=dma_req`. Stays in LOCKED while `dma_lock=1`.
- LOCKED → ARB on the first cycle `dma_lock=0`. That cycle still grants DMA if `dma_req=1`.
- Granted write: next cycle `mem_write=1`, `mem_writeaddr`/`mem_writedata` equal the granted values.
- Granted read: next cycle `mem_readaddr` equals the address, `mem_write=0`.
- Cycles with no grant: `mem_write=0`. Address and data lines hold their previous values.
- Read tag (owner, valid) travels a 2-stage pipe. At stage 2, the owner's `rvalid=1` and `rdata=mem_readdata` for one cycle. The other port's `rvalid=0`.
- `rdata` of a non-owner holds its last value.
- `owner` updates on each grant and holds otherwise.

## Timing
- Request to grant: 0 cycles (combinational).
- Grant to `mem_*` driven: 1 cycle.
- Read grant to `rvalid`: 2 cycles. Back-to-back reads give 1 result per cycle.
- Write to read of the same address in the next cycle returns the new data. `mem_ctrl` write-first ordering is relied upon; the arbiter adds no forwarding.
- Reset (asynchronous, any time): all outputs 0, state ARB, counters 0, tag pipe invalid. In-flight reads are dropped, with no `rvalid` after release.
- The first grant is possible in the first cycle after `reset_n` rises.

## Configuration
- `MEM_ARB_FAIRNESS_EN` defined:
  - A 4-bit counter increments each cycle `dma_req && !dma_gnt` in ARB. When it reaches `STARVE_LIMIT`, DMA wins the next contention. The counter clears on any DMA grant.
  - A second counter tracks cycles with `core_req` pending in LOCKED. At `STARVE_LIMIT`, the FSM forces LOCKED → ARB and grants the core once, ignoring `dma_lock`. The counter clears on exit from LOCKED.
- Not defined: strict core priority, unbounded lock, no counters synthesized.

## Structure
- Shared package `ez8_mem_pkg`:
  - `arb_state_t` (ARB, LOCKED)
  - `owner_t` (OWN_NONE=0, OWN_CORE=1, OWN_DMA=2)
  - default `ADDR_W`/`DATA_W`
- Sub-module `mem_arb_tag_pipe`: 2-stage valid+owner shift register with async reset. It produces the per-port `rvalid` selects.

## Test plan
- Simultaneous read: core addr 0x10, DMA addr 0x20 → `core_gnt=1`, `dma_gnt=0`. `mem_readaddr=0x10` at +1. `core_rvalid` at +2 with `mem_ctrl` data at 0x10. DMA is granted next cycle.
- DMA write 0x5A to 0x33 with `dma_lock=1`, then core requests for 3 cycles → `core_gnt=0` throughout. `mem_write=1` with `mem_writeaddr=0x33`/`mem_writedata=0x5A` at +1. Core is granted the cycle after `dma_lock` falls.
- Back-to-back core reads 0x00..0x03 → four consecutive `core_rvalid` pulses in order, starting 2 cycles after the first grant.
- `reset_n` pulled low one cycle after a read grant → no `rvalid` ever. All outputs 0 while reset is low.
- Fairness on, `STARVE_LIMIT=4`, both requesting continuously → core, core, core, core, DMA grant pattern repeats. Fairness off → DMA never granted.
- Fairness on, DMA holds lock with `core_req=1` → LOCKED forcibly exits after 4 cycles and the core gets one grant.
